block_memory_responder: RTL and testbench

BLOCK_MEMORY_RESPONDER -- requirements
Module: block_memory_responder

---
 rtl/block_memory_responder.sv | 204 ++++++++++++++++++++
 tb/tb_block_memory_responder.sv | 178 +++++++++++++++++
 2 files changed

// File: rtl/block_memory_responder.sv
// block_memory_responder
// Block-oriented backing memory for a cache: accepts whole-block read or write
// requests, waits access_latency cycles, then moves one word per cycle and
// signals completion with a one-cycle done pulse.
//
// Ports
//   clock              single clock, rising edge
//   reset              asynchronous active-high reset
//   mem_read_i         block read request, held until done
//   mem_write_i        block write request, held until done (wins over read)
//   mem_address_i      block address (upper bits beyond mem_depth_log2 ignored)
//   mem_write_data_i   write block, word k at [k*c_line_size +: c_line_size]
//   mem_busywait_o     combinational busy indication
//   mem_read_data_o    read block, same word layout, holds between reads
//   mem_write_done_o   one-cycle write completion pulse
//   mem_read_done_o    one-cycle read completion pulse
module block_memory_responder #(
    parameter int unsigned c_block_size   = 2,
    parameter int unsigned c_line_size    = 32,
    parameter int unsigned address_size   = 32,
    parameter int unsigned mem_line_size  = 32,
    parameter int unsigned mem_depth_log2 = 8,
    parameter int unsigned access_latency = 4
) (
    input  logic                                       clock,
    input  logic                                       reset,
    input  logic                                       mem_read_i,
    input  logic                                       mem_write_i,
    input  logic [address_size-c_block_size-3:0]       mem_address_i,
    input  logic [(2**c_block_size)*c_line_size-1:0]   mem_write_data_i,
    output logic                                       mem_busywait_o,
    output logic [(2**c_block_size)*c_line_size-1:0]   mem_read_data_o,
    output logic                                       mem_write_done_o,
    output logic                                       mem_read_done_o
);

    localparam int unsigned WORDS  = 2**c_block_size;
    localparam int unsigned BLK_W  = WORDS * c_line_size;
    localparam int unsigned ADDR_W = address_size - c_block_size - 2;
    localparam int unsigned BEAT_W = (c_block_size > 0) ? c_block_size : 1;
    localparam int unsigned WAIT_W = (access_latency > 1) ? $clog2(access_latency) : 1;
    localparam int unsigned IDX_W  = mem_depth_log2 + c_block_size;
    localparam int unsigned DEPTH  = 2**IDX_W;

    localparam logic [BEAT_W-1:0] BEAT_LAST = BEAT_W'(WORDS - 1);
    localparam logic [WAIT_W-1:0] WAIT_LAST =
        WAIT_W'((access_latency > 0) ? (access_latency - 1) : 0);

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_WAIT = 2'd1,
        S_BEAT = 2'd2,
        S_DONE = 2'd3
    } state_t;

    state_t                    state_q;
    state_t                    state_nxt;

    logic [mem_depth_log2-1:0] addr_q;
    logic [BLK_W-1:0]          wdata_q;
    logic                      op_write_q;
    logic [BEAT_W-1:0]         beat_q;
    logic [WAIT_W-1:0]         wait_q;
    logic [BLK_W-1:0]          rdata_q;
    logic                      wdone_q;
    logic                      rdone_q;

    logic                      req_c;
    logic                      busy_c;
    logic                      latch_c;
    logic                      mem_we_c;
    logic                      rd_beat_c;
    logic [IDX_W-1:0]          idx_c;
    logic [c_line_size-1:0]    wr_word_c;
    logic [mem_line_size-1:0]  rd_word_c;

    logic [mem_line_size-1:0]  mem_q [DEPTH];

    assign req_c = mem_read_i | mem_write_i;

    // Block addresses wrap: only the low mem_depth_log2 bits select storage.
    if (ADDR_W > mem_depth_log2) begin : g_addr_hi
        logic unused_addr_hi;
        assign unused_addr_hi = ^mem_address_i[ADDR_W-1:mem_depth_log2];
    end

    // State register
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            state_q <= S_IDLE;
        end else begin
            state_q <= state_nxt;
        end
    end

    // Next-state logic
    always_comb begin
        state_nxt = state_q;
        unique case (state_q)
            S_IDLE: begin
                if (req_c) begin
                    state_nxt = (access_latency > 0) ? S_WAIT : S_BEAT;
                end
            end
            S_WAIT: begin
                if (wait_q == WAIT_LAST) begin
                    state_nxt = S_BEAT;
                end
            end
            S_BEAT: begin
                if (beat_q == BEAT_LAST) begin
                    state_nxt = S_DONE;
                end
            end
            S_DONE: begin
                state_nxt = S_IDLE;
            end
            default: begin
                state_nxt = S_IDLE;
            end
        endcase
    end

    // State-decoded controls; busywait is deliberately combinational
    always_comb begin
        busy_c    = 1'b0;
        latch_c   = 1'b0;
        mem_we_c  = 1'b0;
        rd_beat_c = 1'b0;
        unique case (state_q)
            S_IDLE: begin
                busy_c  = req_c;
                latch_c = req_c;
            end
            S_WAIT: begin
                busy_c = 1'b1;
            end
            S_BEAT: begin
                busy_c    = 1'b1;
                mem_we_c  = op_write_q;
                rd_beat_c = ~op_write_q;
            end
            default: begin
                busy_c = 1'b0;
            end
        endcase
    end

    // Word address for the current beat: block * WORDS + beat
    assign idx_c     = (IDX_W'(addr_q) << c_block_size) | IDX_W'(beat_q);
    assign wr_word_c = wdata_q[int'(beat_q) * c_line_size +: c_line_size];
    assign rd_word_c = mem_q[idx_c];

    // Transaction registers and registered outputs
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            addr_q     <= '0;
            wdata_q    <= '0;
            op_write_q <= 1'b0;
            beat_q     <= '0;
            wait_q     <= '0;
            rdata_q    <= '0;
            wdone_q    <= 1'b0;
            rdone_q    <= 1'b0;
        end else begin
            // Done pulse is raised on entry to DONE so it covers exactly that cycle
            wdone_q <= (state_nxt == S_DONE) && op_write_q;
            rdone_q <= (state_nxt == S_DONE) && !op_write_q;

            if (latch_c) begin
                addr_q     <= mem_address_i[mem_depth_log2-1:0];
                wdata_q    <= mem_write_data_i;
                op_write_q <= mem_write_i;
                beat_q     <= '0;
                wait_q     <= '0;
            end

            if (state_q == S_WAIT) begin
                wait_q <= wait_q + WAIT_W'(1);
            end

            if (state_q == S_BEAT) begin
                beat_q <= beat_q + BEAT_W'(1);
            end

            if (rd_beat_c) begin
                rdata_q[int'(beat_q) * c_line_size +: c_line_size] <= c_line_size'(rd_word_c);
            end
        end
    end

    // Storage: never reset, so contents survive an aborted transaction
    always_ff @(posedge clock) begin
        if (mem_we_c) begin
            mem_q[idx_c] <= mem_line_size'(wr_word_c);
        end
    end

    assign mem_busywait_o   = busy_c;
    assign mem_read_data_o  = rdata_q;
    assign mem_write_done_o = wdone_q;
    assign mem_read_done_o  = rdone_q;

endmodule

// File: tb/tb_block_memory_responder.sv
// Directed bench for block_memory_responder: one instance with default
// parameters and one with access_latency = 0, sharing clock and reset.
module tb_block_memory_responder;

    logic         clock;
    logic         reset;

    logic         rd, wr;
    logic [27:0]  addr;
    logic [127:0] wdata;
    logic         busy;
    logic [127:0] rdata;
    logic         wdone, rdone;

    logic         rd0, wr0;
    logic [27:0]  addr0;
    logic [127:0] wdata0;
    logic         busy0;
    logic [127:0] rdata0;
    logic         wdone0, rdone0;

    int checks;
    int failures;

    localparam logic [127:0] D1  = 128'h44444444_33333333_22222222_11111111;
    localparam logic [127:0] D2  = 128'hCAFEF00D_12345678_9ABCDEF0_0F1E2D3C;
    localparam logic [127:0] D3  = 128'h01050105_A5A5A5A5_5A5A5A5A_FFFF0000;
    localparam logic [127:0] OLD = 128'hDDDDDDDD_CCCCCCCC_BBBBBBBB_AAAAAAAA;
    localparam logic [127:0] NEW = 128'h88888888_77777777_66666666_55555555;
    localparam logic [127:0] MIX = 128'hDDDDDDDD_CCCCCCCC_66666666_55555555;

    block_memory_responder u_dut (
        .clock            (clock),
        .reset            (reset),
        .mem_read_i       (rd),
        .mem_write_i      (wr),
        .mem_address_i    (addr),
        .mem_write_data_i (wdata),
        .mem_busywait_o   (busy),
        .mem_read_data_o  (rdata),
        .mem_write_done_o (wdone),
        .mem_read_done_o  (rdone)
    );

    block_memory_responder #(.access_latency(0)) u_dut0 (
        .clock            (clock),
        .reset            (reset),
        .mem_read_i       (rd0),
        .mem_write_i      (wr0),
        .mem_address_i    (addr0),
        .mem_write_data_i (wdata0),
        .mem_busywait_o   (busy0),
        .mem_read_data_o  (rdata0),
        .mem_write_done_o (wdone0),
        .mem_read_done_o  (rdone0)
    );

    initial begin
        clock = 1'b0;
        forever #5 clock = ~clock;
    end

    task automatic check(input string tag, input logic [127:0] obs, input logic [127:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic drive(input bit sel, input bit w, input bit r,
                         input logic [27:0] a, input logic [127:0] d);
        if (sel) begin
            wr0 = w; rd0 = r; addr0 = a; wdata0 = d;
        end else begin
            wr = w; rd = r; addr = a; wdata = d;
        end
    endtask

    task automatic sample(input bit sel, output logic b, output logic [1:0] dn);
        if (sel) begin
            b = busy0; dn = {wdone0, rdone0};
        end else begin
            b = busy; dn = {wdone, rdone};
        end
    endtask

    // Runs one transaction starting just after a rising edge (cycle 0 = latch
    // cycle). Checks busywait and done pulses each cycle, scrambles the request
    // payload after the latch edge, drops the request on the edge ending DONE.
    task automatic txn(input bit sel, input bit w, input bit r, input logic [27:0] a,
                       input logic [127:0] d, input int done_cyc, input string tag);
        logic       b;
        logic [1:0] dn;
        drive(sel, w, r, a, d);
        for (int c = 0; c <= done_cyc; c++) begin
            #4;
            sample(sel, b, dn);
            check({tag, "_busy"}, 128'(b), 128'(c != done_cyc));
            check({tag, "_done"}, 128'(dn), (c == done_cyc) ? 128'({w, r & ~w}) : 128'(0));
            @(posedge clock); #1;
            if (c == 0) drive(sel, w, r, a ^ 28'h1, ~d);
        end
        drive(sel, 1'b0, 1'b0, '0, '0);
        #4;
        sample(sel, b, dn);
        check({tag, "_idle"}, 128'({b, dn}), 128'(0));
        @(posedge clock); #1;
    endtask

    initial begin
        logic       b;
        logic [1:0] dn;
        logic       seen;
        checks   = 0;
        failures = 0;
        reset    = 1'b1;
        drive(1'b0, 1'b0, 1'b0, '0, '0);
        drive(1'b1, 1'b0, 1'b0, '0, '0);

        #12;
        check("rst_busy",  128'(busy),  128'(0));
        check("rst_done",  128'({wdone, rdone}), 128'(0));
        check("rst_rdata", rdata, 128'(0));
        reset = 1'b0;
        @(posedge clock); #1;

        // Write then read block 0x05
        txn(1'b0, 1'b1, 1'b0, 28'h05, D1, 9, "wr05");
        txn(1'b0, 1'b0, 1'b1, 28'h05, '0, 9, "rd05");
        check("rd05_data", rdata, D1);

        // Simultaneous request performs the write only; read data unchanged
        txn(1'b0, 1'b1, 1'b1, 28'h10, D2, 9, "both10");
        check("both10_rdata_hold", rdata, D1);
        txn(1'b0, 1'b0, 1'b1, 28'h10, '0, 9, "rd10");
        check("rd10_data", rdata, D2);

        // Address wrap modulo 256 blocks
        txn(1'b0, 1'b1, 1'b0, 28'h105, D3, 9, "wr105");
        txn(1'b0, 1'b0, 1'b1, 28'h005, '0, 9, "rd005");
        check("wrap_data", rdata, D3);

        // Reset during BEAT after two words written
        txn(1'b0, 1'b1, 1'b0, 28'h20, OLD, 9, "wr20old");
        drive(1'b0, 1'b1, 1'b0, 28'h20, NEW);
        for (int c = 0; c < 7; c++) begin
            @(posedge clock); #1;
        end
        reset = 1'b1;
        drive(1'b0, 1'b0, 1'b0, '0, '0);
        #1;
        check("abort_busy",  128'(busy), 128'(0));
        check("abort_done",  128'({wdone, rdone}), 128'(0));
        check("abort_rdata", rdata, 128'(0));
        @(posedge clock); #1;
        reset = 1'b0;
        seen  = 1'b0;
        for (int c = 0; c < 12; c++) begin
            #4;
            sample(1'b0, b, dn);
            if (b || (dn != 2'b00)) seen = 1'b1;
            @(posedge clock); #1;
        end
        check("abort_no_pulse", 128'(seen), 128'(0));
        txn(1'b0, 1'b0, 1'b1, 28'h20, '0, 9, "rd20");
        check("abort_partial_data", rdata, MIX);

        // Zero-latency instance: done in cycle W+1 = 5
        txn(1'b1, 1'b1, 1'b0, 28'h03, D2, 5, "l0_wr");
        txn(1'b1, 1'b0, 1'b1, 28'h03, '0, 5, "l0_rd");
        check("l0_data", rdata0, D2);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
